// File: rtl/fxp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fxp_addsub_pipe
//
// Pipelined sign-magnitude fixed-point add/subtract unit. It computes
// c = a + b (sub=0) or c = a - b (sub=1) over two registered stages, with
// valid/ready flow control on both sides and magnitude overflow detection.
//
// Word format: bit N-1 is the sign, bits N-2:0 are the magnitude, and the
// low Q bits of the magnitude are fractional. Q only describes the format;
// it does not affect the arithmetic.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat this cycle
//   a, b       operands (sign-magnitude, N bits)
//   sub        0: c = a + b, 1: c = a - b
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   c          result (sign-magnitude, N bits)
//   ovf        magnitude overflow for this result, qualified by out_valid
//
// Build option:
//   FXP_ADDSUB_SAT_EN  when defined, an ADD overflow saturates the magnitude
//                      to all ones; otherwise the carry is dropped (wrap).
//                      ovf is raised in both builds.
// ---------------------------------------------------------------------------
module fxp_addsub_pipe #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  // Magnitude width.
  localparam int M = N - 1;

  // Reject illegal configurations at elaboration time.
  if (N < 4) begin : gBadN
    $error("fxp_addsub_pipe: N must be at least 4");
  end
  if ((Q < 0) || (Q > N - 2)) begin : gBadQ
    $error("fxp_addsub_pipe: Q must lie in 0..N-2");
  end

  // Operation decided in S1 from the effective signs.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic         s1Valid_q, s1Valid_d;
  logic         s1Sa_q,    s1Sa_d;
  logic         s1Sb_q,    s1Sb_d;
  logic [M-1:0] s1MagA_q,  s1MagA_d;
  logic [M-1:0] s1MagB_q,  s1MagB_d;
  logic         s1AGeB_q,  s1AGeB_d;
  op_e          s1Op_q,    s1Op_d;

  logic         s2Valid_q, s2Valid_d;
  logic [N-1:0] c_q,       c_d;
  logic         ovf_q,     ovf_d;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic inFire;
  logic outFire;
  logic s2CanLoad;
  logic s1Advance;

  // S2 frees up either by being empty or by handing its result downstream
  // this cycle; S1 frees up either by being empty or by moving into S2.
  // in_ready therefore depends on out_ready but never on in_valid.
  assign outFire   = s2Valid_q && out_ready;
  assign s2CanLoad = !s2Valid_q || out_ready;
  assign s1Advance = s1Valid_q && s2CanLoad;
  assign in_ready  = !s1Valid_q || s2CanLoad;
  assign inFire    = in_valid && in_ready;

  assign out_valid = s2Valid_q;
  assign c         = c_q;
  assign ovf       = ovf_q;

  // -------------------------------------------------------------------------
  // Stage 1: operand decode
  // -------------------------------------------------------------------------
  logic         inSa;
  logic         inSb;
  logic [M-1:0] inMagA;
  logic [M-1:0] inMagB;

  // Subtraction is folded into the sign of b, so S2 only ever sees a
  // same-sign add or an opposite-sign magnitude subtract.
  assign inSa   = a[N-1];
  assign inSb   = b[N-1] ^ sub;
  assign inMagA = a[M-1:0];
  assign inMagB = b[M-1:0];

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Sa_d    = s1Sa_q;
    s1Sb_d    = s1Sb_q;
    s1MagA_d  = s1MagA_q;
    s1MagB_d  = s1MagB_q;
    s1AGeB_d  = s1AGeB_q;
    s1Op_d    = s1Op_q;
    if (inFire) begin
      s1Valid_d = 1'b1;
      s1Sa_d    = inSa;
      s1Sb_d    = inSb;
      s1MagA_d  = inMagA;
      s1MagB_d  = inMagB;
      s1AGeB_d  = (inMagA >= inMagB);
      s1Op_d    = (inSa == inSb) ? OP_ADD : OP_SUB;
    end else if (s1Advance) begin
      s1Valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Sa_q    <= 1'b0;
      s1Sb_q    <= 1'b0;
      s1MagA_q  <= '0;
      s1MagB_q  <= '0;
      s1AGeB_q  <= 1'b0;
      s1Op_q    <= OP_ADD;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Sa_q    <= s1Sa_d;
      s1Sb_q    <= s1Sb_d;
      s1MagA_q  <= s1MagA_d;
      s1MagB_q  <= s1MagB_d;
      s1AGeB_q  <= s1AGeB_d;
      s1Op_q    <= s1Op_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: magnitude arithmetic and result formatting
  // -------------------------------------------------------------------------
  logic [N-1:0] magSum;
  logic         sumCarry;
  logic [M-1:0] magDiff;
  logic         bothZero;
  logic [M-1:0] resMag;
  logic         resSign;
  logic         resOvf;

  // The sum is one bit wider than a magnitude so its MSB is the carry out.
  assign magSum   = {1'b0, s1MagA_q} + {1'b0, s1MagB_q};
  assign sumCarry = magSum[N-1];
  assign magDiff  = s1AGeB_q ? (s1MagA_q - s1MagB_q) : (s1MagB_q - s1MagA_q);
  assign bothZero = (s1MagA_q == '0) && (s1MagB_q == '0);

  always_comb begin
    resMag  = '0;
    resSign = 1'b0;
    resOvf  = 1'b0;
    unique case (s1Op_q)
      OP_ADD: begin
        resOvf = sumCarry;
`ifdef FXP_ADDSUB_SAT_EN
        resMag = sumCarry ? {M{1'b1}} : magSum[M-1:0];
`else
        resMag = magSum[M-1:0];
`endif
        // Two zeros of either sign add to +0.
        resSign = bothZero ? 1'b0 : s1Sa_q;
      end
      OP_SUB: begin
        resMag = magDiff;
        // Equal magnitudes cancel to +0; otherwise the larger one wins.
        if (s1MagA_q == s1MagB_q) begin
          resSign = 1'b0;
        end else begin
          resSign = s1AGeB_q ? s1Sa_q : s1Sb_q;
        end
      end
      default: begin
        resMag  = '0;
        resSign = 1'b0;
        resOvf  = 1'b0;
      end
    endcase
  end

  // c/ovf only change when a new beat enters S2, so they hold while stalled
  // and simply keep their last value once the stage drains.
  always_comb begin
    s2Valid_d = s2Valid_q;
    c_d       = c_q;
    ovf_d     = ovf_q;
    if (s1Advance) begin
      s2Valid_d = 1'b1;
      c_d       = {resSign, resMag};
      ovf_d     = resOvf;
    end else if (outFire) begin
      s2Valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      c_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      s2Valid_q <= s2Valid_d;
      c_q       <= c_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_fxp_addsub_pipe
//
// Bench for fxp_addsub_pipe (N=32, Q=15). A driver issues beats and pushes
// the expected result of each accepted beat into a queue; an independent
// monitor pops and compares whenever a result is handed downstream. The
// expected values come from a signed-integer reference model or from
// literal vectors. Define FXP_ADDSUB_SAT_EN to match a saturating build.
// ---------------------------------------------------------------------------
module tb_fxp_addsub_pipe;

  localparam int N = 32;
  localparam int Q = 15;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         ovf;

  fxp_addsub_pipe #(.Q(Q), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] c;
    logic         ovf;
    int           cyc;
    bit           strict;
  } exp_t;

  exp_t expQ[$];
  int   cycle = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   acceptCount = 0;
  int   outCount = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  // Reference: interpret operands as signed integers, add, then map back
  // to sign-magnitude with the overflow policy applied.
  function automatic logic [N:0] refModel(input logic [N-1:0] av,
                                          input logic [N-1:0] bv,
                                          input logic s);
    longint maxMag = (longint'(1) << (N - 1)) - 1;
    longint magA   = longint'(av[N-2:0]);
    longint magB   = longint'(bv[N-2:0]);
    bit     sa     = av[N-1];
    bit     sb     = bv[N-1] ^ s;
    longint va     = sa ? -magA : magA;
    longint vb     = sb ? -magB : magB;
    longint r;
    bit     sign;
    bit     o = 1'b0;
    logic [63:0] rBits;
    if (sa == sb) begin
      r = magA + magB;
      if (r > maxMag) begin
        o = 1'b1;
`ifdef FXP_ADDSUB_SAT_EN
        r = maxMag;
`else
        r = r - (maxMag + 1);
`endif
      end
      sign = (magA == 0 && magB == 0) ? 1'b0 : sa;
    end else begin
      r    = va + vb;
      sign = (r < 0);
      if (r < 0) r = -r;
    end
    rBits = r;
    return {o, sign, rBits[N-2:0]};
  endfunction

  // Present one beat from the next falling edge and hold it until accepted.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic sv, input logic [N-1:0] expC,
                               input logic expOvf, input bit strict);
    exp_t e;
    bit   done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      sub      = sv;
      #1;
      if (in_ready) begin
        e.c      = expC;
        e.ovf    = expOvf;
        e.cyc    = cycle;
        e.strict = strict;
        expQ.push_back(e);
        acceptCount++;
        done = 1'b1;
      end
    end
    if (!done) checkOutput("accept timeout", 64'(in_ready), 64'(1));
  endtask

  task automatic applyModelBeat(input logic [N-1:0] av, input logic [N-1:0] bv,
                                input logic sv, input bit strict);
    logic [N:0] r;
    r = refModel(av, bv, sv);
    applyStimulus(av, bv, sv, r[N-1:0], r[N], strict);
  endtask

  task automatic goIdle();
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    sub      = $urandom_range(0, 1);
  endtask

  // Monitor: scores every output transfer and checks c/ovf stability
  // across stalled cycles.
  initial begin : monitor
    exp_t        e;
    bit          prevStalled = 1'b0;
    logic [N-1:0] prevC = '0;
    logic        prevOvf = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prevStalled = 1'b0;
      end else begin
        if (prevStalled && out_valid) begin
          checkOutput("stall c stable", 64'(c), 64'(prevC));
          checkOutput("stall ovf stable", 64'(ovf), 64'(prevOvf));
        end
        if (out_valid && out_ready) begin
          outCount++;
          if (expQ.size() == 0) begin
            checkOutput("spurious out_valid", 64'(out_valid), 64'(0));
          end else begin
            e = expQ.pop_front();
            checkOutput("c", 64'(c), 64'(e.c));
            checkOutput("ovf", 64'(ovf), 64'(e.ovf));
            if (e.strict) checkOutput("latency", 64'(cycle - e.cyc), 64'(2));
          end
        end
        prevStalled = out_valid && !out_ready;
        prevC       = c;
        prevOvf     = ovf;
      end
    end
  end

  initial begin : driver
    int startOut;
    int randAccepted;
    int guard;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset c", 64'(c), 64'(0));
    checkOutput("reset ovf", 64'(ovf), 64'(0));
    checkOutput("reset in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with literal expectations, full rate.
    applyStimulus(32'h00008000, 32'h00010000, 1'b0, 32'h00018000, 1'b0, 1'b1);
    applyStimulus(32'h00008000, 32'h00010000, 1'b1, 32'h80008000, 1'b0, 1'b1);
    applyStimulus(32'h80008000, 32'h00004000, 1'b1, 32'h8000C000, 1'b0, 1'b1);
    applyStimulus(32'h00008000, 32'h80008000, 1'b0, 32'h00000000, 1'b0, 1'b1);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b1);
`ifdef FXP_ADDSUB_SAT_EN
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
`else
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1'b1);
`endif
    applyStimulus(32'h00001234, 32'h00001234, 1'b1, 32'h00000000, 1'b0, 1'b1);
    applyModelBeat(32'h80010000, 32'h00030000, 1'b0, 1'b1);
    applyModelBeat(32'h40000000, 32'hC0000000, 1'b1, 1'b1);
    goIdle();
    repeat (4) @(negedge clk);

    // Backpressure: four beats against a six-cycle stall.
    out_ready = 1'b0;
    acceptCount = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyModelBeat($urandom, $urandom, 1'($urandom), 1'b0);
        goIdle();
      end
      begin
        repeat (3) @(negedge clk);
        #2;
        checkOutput("bp accepted before full", 64'(acceptCount), 64'(2));
        checkOutput("bp in_ready low", 64'(in_ready), 64'(0));
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        startOut  = outCount;
        repeat (3) @(negedge clk);
        #3;
        checkOutput("bp drain rate", 64'(outCount - startOut), 64'(4));
      end
    join
    repeat (4) @(negedge clk);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    applyModelBeat(32'h00000011, 32'h00000022, 1'b0, 1'b0);
    applyModelBeat(32'h00000033, 32'h00000044, 1'b1, 1'b0);
    goIdle();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset c", 64'(c), 64'(0));
    checkOutput("midreset ovf", 64'(ovf), 64'(0));
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("post-reset in_ready", 64'(in_ready), 64'(1));
    repeat (4) @(negedge clk);
    #1;
    checkOutput("post-reset out_valid", 64'(out_valid), 64'(0));

    // Random regression with random valid/ready toggling.
    randAccepted = 0;
    guard = 0;
    while (randAccepted < 1000 && guard < 20000) begin
      @(negedge clk);
      guard++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = {1'($urandom), ra[N-2:0]};
        1: begin ra[N-2:N-4] = 3'b111; rb[N-2:N-4] = 3'b111; end
        2: begin ra[N-2:0] = '0; rb[N-2:0] = '0; end
        default: ;
      endcase
      a   = ra;
      b   = rb;
      sub = $urandom_range(0, 1);
      #1;
      if (in_valid && in_ready) begin
        exp_t e;
        logic [N:0] r;
        r        = refModel(a, b, sub);
        e.c      = r[N-1:0];
        e.ovf    = r[N];
        e.cyc    = cycle;
        e.strict = 1'b0;
        expQ.push_back(e);
        randAccepted++;
      end
    end
    checkOutput("random beats accepted", 64'(randAccepted), 64'(1000));
    goIdle();
    out_ready = 1'b1;

    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'(0));
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
